ifu_inst_queue: RTL and testbench
=================================

Name: ifu_inst_queue

Overview:
- Instruction queue between the fetch unit and the decode stage.
- Buffers fetched instructions, their PCs, the branch-prediction bit and the AXI read-error bit.
- Decouples fetch-bus latency from decode stalls; drops all buffered entries on a pipeline flush.
- Producer side is the fetch unit's valid-qualified instruction output. Consumer side is a valid/ready interface to ID.

Parameters:
- DEPTH, 4, number of entries; must be a power of 2 and at least 2.
- NOP_INST, 32'h00000013, instruction word presented in place of an errored fetch.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush (jump or redirect); discards all entries
- in_valid_i  in  1  fetched instruction valid
- in_ready_o  out  1  queue can accept (not full)
- in_inst_i  in  `INST_DATA_WIDTH  instruction word
- in_addr_i  in  `INST_ADDR_WIDTH  instruction PC
- in_branch_taken_i  in  1  predicted-taken flag for this instruction
- in_resp_err_i  in  1  AXI read response error for this fetch
- out_valid_o  out  1  head entry valid toward ID
- out_ready_i  in  1  ID accepts the head this cycle (low when ID is stalled)
- out_inst_o  out  `INST_DATA_WIDTH  head instruction; NOP_INST if the head is errored
- out_addr_o  out  `INST_ADDR_WIDTH  head PC
- out_branch_taken_o  out  1  head prediction flag
- out_resp_err_o  out  1  head fetch faulted
- count_o  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Clock/reset: single clock, clk; asynchronous active-low reset, rst_n. Reset clears both pointers, every entry valid bit and count.
- Outputs at reset: out_valid_o=0, in_ready_o=1, count_o=0. out_inst_o=NOP_INST, out_addr_o=0, out_branch_taken_o=0, out_resp_err_o=0.
- Storage: circular buffer of DEPTH entries. Each entry holds {inst, addr, branch_taken, resp_err}.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits. The MSB is the wrap bit.
  - full: the index bits are equal and the wrap bits differ.
  - empty: the pointers are equal.
- Push: in_valid_i && in_ready_o. Writes at wr_ptr and increments wr_ptr, with natural wrap.
- Pop: out_valid_o && out_ready_i. Increments rd_ptr.
- in_ready_o = !full && !flush_i, combinational.
- out_valid_o = !empty && !flush_i, combinational.
- Head outputs come combinationally from the entry at rd_ptr. When the queue is empty they show the reset values.
- Latency: a pushed entry is visible at the output in the cycle after the push (one cycle, no bypass).
- Simultaneous push and pop:
  - Allowed whenever neither side is blocked; count is unchanged.
  - When full, no push occurs even if a pop happens the same cycle (in_ready_o is already 0).
  - When empty, no pop occurs.
- count_o = wr_ptr - rd_ptr, modulo 2^($clog2(DEPTH)+1). It is registered and consistent with the pointers.
- Flush:
  - In the flush_i cycle, push and pop are both suppressed.
  - On the next clock edge rd_ptr is set to wr_ptr, making the queue empty and count 0.
  - A flush takes priority over any concurrent push or pop.
- Error entry: if the head has resp_err=1, out_inst_o=NOP_INST and out_resp_err_o=1. It pops normally so ID can raise the access fault. The original instruction data is not forwarded.
- Reset mid-operation: contents are discarded immediately. No partial pop or push completes.
- No X propagation: entry data registers need no reset. The output mux must select reset values when the queue is empty.

Optional Feature:
- IFU_IQ_BYPASS_EN
- Defined:
  - When the queue is empty, in_valid_i=1, out_ready_i=1 and flush_i=0, the input is forwarded combinationally to the outputs with out_valid_o=1.
  - In that cycle the entry is not written and the pointers do not move. Latency is 0.
  - If out_ready_i=0, the entry is enqueued as normal.
- Undefined: no combinational input-to-output path. Minimum latency is 1 cycle.

Decomposition:
- Shared package (ifu_pkg): typedef iq_entry_t {inst, addr, branch_taken, resp_err}; the NOP_INST constant. Widths come from defines.svh.
- Optional sub-module ifu_iq_ptr: parameterised wrap-bit pointer with inc and load, instantiated twice. Everything else stays in ifu_inst_queue.

Test Plan:
- Fill, then drain in order: DEPTH=4, out_ready_i=0, push PCs 0x80000000..0x8000000C → after 4 pushes in_ready_o=0 and count_o=4. Set out_ready_i=1 → PCs pop in order at one per cycle, then out_valid_o=0.
- Concurrent push and pop in steady state: hold count=2 with in_valid_i=1 and out_ready_i=1 for 10 cycles → count_o stays 2; 10 entries pass in order; pointer wrap is exercised.
- Flush with concurrent push: 3 entries queued; flush_i=1 with in_valid_i=1 (PC 0x80000020) → out_valid_o=0 in that cycle; count_o=0 next cycle; PC 0x80000020 is never output.
- Errored fetch: push inst 0xDEADBEEF with in_resp_err_i=1 at PC 0x80000040 → head shows out_inst_o=0x00000013, out_resp_err_o=1, out_addr_o=0x80000040.
- Reset mid-operation: 2 entries queued; pulse rst_n low asynchronously, between clock edges → out_valid_o=0 and count_o=0 immediately, in_ready_o=1.
- Bypass (IFU_IQ_BYPASS_EN): queue empty; push PC 0x80000100 with out_ready_i=1 → out_valid_o=1 with out_addr_o=0x80000100 in the same cycle, count_o stays 0. Without the macro, the entry appears one cycle later.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the IFU instruction queue.
// Widths default here unless INST_DATA_WIDTH / INST_ADDR_WIDTH are predefined.
`ifndef INST_DATA_WIDTH
`define INST_DATA_WIDTH 32
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

package ifu_pkg;

    localparam int unsigned INST_DATA_W = `INST_DATA_WIDTH;
    localparam int unsigned INST_ADDR_W = `INST_ADDR_WIDTH;

    localparam logic [INST_DATA_W-1:0] IQ_NOP_INST = INST_DATA_W'(32'h0000_0013);

    typedef struct packed {
        logic [INST_DATA_W-1:0] inst;
        logic [INST_ADDR_W-1:0] addr;
        logic                   branch_taken;
        logic                   resp_err;
    } iq_entry_t;

endpackage

// File: rtl/ifu_iq_ptr.sv
// Wrap-bit queue pointer with increment and parallel load.
module ifu_iq_ptr #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] ptr
);

    // Load wins over increment so a flush overrides a concurrent pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/ifu_inst_queue.sv
// Fetch-to-decode instruction queue with flush and errored-fetch substitution.
// Optional zero-latency empty-queue bypass under IFU_IQ_BYPASS_EN.
module ifu_inst_queue
    import ifu_pkg::*;
#(
    parameter int unsigned            DEPTH    = 4,
    parameter logic [INST_DATA_W-1:0] NOP_INST = IQ_NOP_INST
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [INST_DATA_W-1:0]         in_inst_i,
    input  logic [INST_ADDR_W-1:0]         in_addr_i,
    input  logic                           in_branch_taken_i,
    input  logic                           in_resp_err_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [INST_DATA_W-1:0]         out_inst_o,
    output logic [INST_ADDR_W-1:0]         out_addr_o,
    output logic                           out_branch_taken_o,
    output logic                           out_resp_err_o,
    output logic [$clog2(DEPTH):0]         count_o
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    iq_entry_t         mem [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     count_q;
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;
    logic              full;
    logic              empty;
    logic              bypass;
    logic              push;
    logic              pop;
    iq_entry_t         head;

    assign wr_idx = wr_ptr[IW-1:0];
    assign rd_idx = rd_ptr[IW-1:0];
    assign full   = (wr_idx == rd_idx) && (wr_ptr[IW] != rd_ptr[IW]);
    assign empty  = (wr_ptr == rd_ptr);

`ifdef IFU_IQ_BYPASS_EN
    assign bypass = empty && in_valid_i && out_ready_i && !flush_i;
`else
    assign bypass = 1'b0;
`endif

    assign in_ready_o  = !full && !flush_i;
    assign out_valid_o = (!empty && !flush_i) || bypass;
    assign push        = in_valid_i && in_ready_o && !bypass;
    assign pop         = !empty && !flush_i && out_ready_i;
    assign count_o     = count_q;

    ifu_iq_ptr #(.W(PW)) u_wr_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (push),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (wr_ptr)
    );

    ifu_iq_ptr #(.W(PW)) u_rd_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (pop),
        .load     (flush_i),
        .load_val (wr_ptr),
        .ptr      (rd_ptr)
    );

    // Entry payload needs no reset; the output mux hides stale data.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= '{inst:         in_inst_i,
                             addr:         in_addr_i,
                             branch_taken: in_branch_taken_i,
                             resp_err:     in_resp_err_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                valid_q[rd_idx] <= 1'b0;
            end
            if (push) begin
                valid_q[wr_idx] <= 1'b1;
            end
            count_q <= count_q + PW'(push) - PW'(pop);
        end
    end

    // Head select: bypassed input, stored head, or reset values when empty.
    always_comb begin
        head = '{inst: NOP_INST, addr: '0, branch_taken: 1'b0, resp_err: 1'b0};
        if (bypass) begin
            head = '{inst:         in_inst_i,
                     addr:         in_addr_i,
                     branch_taken: in_branch_taken_i,
                     resp_err:     in_resp_err_i};
        end else if (!empty && valid_q[rd_idx]) begin
            head = mem[rd_idx];
        end
    end

    assign out_inst_o         = head.resp_err ? NOP_INST : head.inst;
    assign out_addr_o         = head.addr;
    assign out_branch_taken_o = head.branch_taken;
    assign out_resp_err_o     = head.resp_err;

endmodule

// File: tb/tb_ifu_inst_queue.sv
// Directed scoreboard bench for ifu_inst_queue; honours IFU_IQ_BYPASS_EN when defined.
module tb_ifu_inst_queue;
    import ifu_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic                   clk;
    logic                   rst_n;
    logic                   flush_i;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [INST_DATA_W-1:0] in_inst_i;
    logic [INST_ADDR_W-1:0] in_addr_i;
    logic                   in_branch_taken_i;
    logic                   in_resp_err_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [INST_DATA_W-1:0] out_inst_o;
    logic [INST_ADDR_W-1:0] out_addr_o;
    logic                   out_branch_taken_o;
    logic                   out_resp_err_o;
    logic [$clog2(DEPTH):0] count_o;

    int checks;
    int errors;
    iq_entry_t sb[$];

    ifu_inst_queue #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .flush_i            (flush_i),
        .in_valid_i         (in_valid_i),
        .in_ready_o         (in_ready_o),
        .in_inst_i          (in_inst_i),
        .in_addr_i          (in_addr_i),
        .in_branch_taken_i  (in_branch_taken_i),
        .in_resp_err_i      (in_resp_err_i),
        .out_valid_o        (out_valid_o),
        .out_ready_i        (out_ready_i),
        .out_inst_o         (out_inst_o),
        .out_addr_o         (out_addr_o),
        .out_branch_taken_o (out_branch_taken_o),
        .out_resp_err_o     (out_resp_err_o),
        .count_o            (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare the head outputs against an expected entry.
    task automatic chk_head(input iq_entry_t e);
        chk("out_inst", 64'(out_inst_o), e.resp_err ? 64'(NOP) : 64'(e.inst));
        chk("out_addr", 64'(out_addr_o), 64'(e.addr));
        chk("out_bt",   64'(out_branch_taken_o), 64'(e.branch_taken));
        chk("out_err",  64'(out_resp_err_o), 64'(e.resp_err));
    endtask

    // Drive one cycle, check against the scoreboard, then update it. Called at posedge+1.
    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] addr,
                        input logic bt, input logic err, input logic rdy, input logic fl);
        logic      empty;
        logic      full;
        logic      byp;
        iq_entry_t e;
        in_valid_i        = v;
        in_inst_i         = INST_DATA_W'(inst);
        in_addr_i         = INST_ADDR_W'(addr);
        in_branch_taken_i = bt;
        in_resp_err_i     = err;
        out_ready_i       = rdy;
        flush_i           = fl;
        #2;
        e     = '{inst: INST_DATA_W'(inst), addr: INST_ADDR_W'(addr), branch_taken: bt, resp_err: err};
        empty = (sb.size() == 0);
        full  = (sb.size() == DEPTH);
        byp   = 1'b0;
`ifdef IFU_IQ_BYPASS_EN
        byp   = empty && v && rdy && !fl;
`endif
        chk("in_ready",  64'(in_ready_o),  64'(!full && !fl));
        chk("out_valid", 64'(out_valid_o), 64'((!empty && !fl) || byp));
        chk("count",     64'(count_o),     64'(sb.size()));
        if (byp) begin
            chk_head(e);
        end else if (!empty && !fl) begin
            chk_head(sb[0]);
        end else if (empty) begin
            chk_head('{inst: INST_DATA_W'(NOP), addr: '0, branch_taken: 1'b0, resp_err: 1'b0});
        end
        if (fl) begin
            sb.delete();
        end else begin
            if (!empty && rdy) void'(sb.pop_front());
            if (v && !full && !byp) sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        in_inst_i = '0;
        in_addr_i = '0;
        in_branch_taken_i = 1'b0;
        in_resp_err_i = 1'b0;
        out_ready_i = 1'b0;
        #3;
        chk("rst_out_valid", 64'(out_valid_o), 64'(0));
        chk("rst_in_ready",  64'(in_ready_o),  64'(1));
        chk("rst_count",     64'(count_o),     64'(0));
        chk("rst_inst",      64'(out_inst_o),  64'(NOP));
        chk("rst_addr",      64'(out_addr_o),  64'(0));
        chk("rst_bt",        64'(out_branch_taken_o), 64'(0));
        chk("rst_err",       64'(out_resp_err_o), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill with ID stalled, then a full-and-pop cycle, then drain.
        for (int i = 0; i < 4; i++)
            step(1'b1, $urandom, 32'h8000_0000 + 32'(4 * i), 1'(i & 1), 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        step(1'b1, 32'h1111_1111, 32'h8000_00F0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Steady-state concurrent push/pop at occupancy 2, wrapping pointers.
        step(1'b1, $urandom, 32'h8000_0200, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, $urandom, 32'h8000_0204, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            step(1'b1, $urandom, 32'h8000_0208 + 32'(4 * i), 1'($urandom_range(1)), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Flush with a concurrent push; the flushed-cycle PC must never appear.
        for (int i = 0; i < 3; i++)
            step(1'b1, $urandom, 32'h8000_0010 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hCAFE_0001, 32'h8000_0020, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Errored fetch shows NOP with the fault flag.
        step(1'b1, 32'hDEAD_BEEF, 32'h8000_0040, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset between clock edges.
        step(1'b1, $urandom, 32'h8000_0080, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, $urandom, 32'h8000_0084, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid_o), 64'(0));
        chk("mid_rst_count",     64'(count_o),     64'(0));
        chk("mid_rst_in_ready",  64'(in_ready_o),  64'(1));
        sb.delete();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(1'b1);

        // Empty queue, consumer ready: same-cycle with bypass, next cycle without.
        step(1'b1, 32'h0000_0513, 32'h8000_0100, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
